// File: rtl/fpu_arbiter.sv
// Purpose: round-robin share of one pipelined, non-stalling FPU among NUM_REQ requesters, with results routed back by tag.
// Latency: grant is combinational; issue to the FPU is registered (+1); the response arrives FPU_LATENCY cycles after issue.
// Backpressure: req_ready grants one requester per cycle; the FPU and the responses take no backpressure (resp_valid is a strobe).
//
// Ports:
//   clk, rst_n                                      clock, async active-low reset
//   req_valid/req_ready                             per-requester handshake (ready is a one-hot grant)
//   req_operand_a/b, req_operation                  packed per-requester operands, requester i at [i*W +: W]
//   resp_valid, resp_result, resp_exception         per-requester result strobe plus shared result bus
//   fpu_valid_in, fpu_operand_a/b, fpu_operation    registered FPU issue port
//   fpu_valid_out, fpu_result, fpu_exception        FPU result port
//   busy, proto_err                                 activity indicator, sticky tag/FPU disagreement flag
module fpu_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 32,
    parameter int FPU_LATENCY = 2,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_operand_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_operand_b,
    input  logic [NUM_REQ*3-1:0]      req_operation,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_result,
    output logic                      resp_exception,
    output logic                      fpu_valid_in,
    output logic [DATA_W-1:0]         fpu_operand_a,
    output logic [DATA_W-1:0]         fpu_operand_b,
    output logic [2:0]                fpu_operation,
    input  logic                      fpu_valid_out,
    input  logic [DATA_W-1:0]         fpu_result,
    input  logic                      fpu_exception,
    output logic                      busy,
    output logic                      proto_err
);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] scan_id;
    logic            found;
    logic            transfer;
    int              scan_idx;

    // One extra stage over the FPU latency covers the issue register.
    tag_t tag_q [FPU_LATENCY+1];
    tag_t tail;

    // Round-robin scan starting at rr_ptr; first pending requester wins.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = 0;
        scan_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
            scan_id  = ID_W'(scan_idx);
            if (!found && req_valid[scan_id]) begin
                found  = 1'b1;
                winner = scan_id;
            end
        end
    end

    // Grants are suppressed while reset is held so nothing is accepted that would be dropped.
    assign transfer = found & rst_n;

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            rr_ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    // Operand registers only load on a transfer so the FPU inputs stay quiet when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpu_valid_in  <= 1'b0;
            fpu_operand_a <= '0;
            fpu_operand_b <= '0;
            fpu_operation <= '0;
        end else begin
            fpu_valid_in <= transfer;
            if (transfer) begin
                fpu_operand_a <= req_operand_a[winner*DATA_W +: DATA_W];
                fpu_operand_b <= req_operand_b[winner*DATA_W +: DATA_W];
                fpu_operation <= req_operation[winner*3 +: 3];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= FPU_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= {transfer, winner};
            for (int k = 1; k <= FPU_LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign tail = tag_q[FPU_LATENCY];

    // Requiring both strobes means a tag/FPU disagreement never produces a response.
    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = fpu_valid_out & tail.vld & (tail.id == ID_W'(i));
        end
    end

    assign resp_result    = fpu_result;
    assign resp_exception = fpu_exception;

    always_comb begin
        busy = fpu_valid_in;
        for (int k = 0; k <= FPU_LATENCY; k++) begin
            busy = busy | tag_q[k].vld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
        end else if (fpu_valid_out != tail.vld) begin
            proto_err <= 1'b1;
        end
    end

endmodule
